safe_lock_ctrl: RTL and testbench

SAFE_LOCK_CTRL -- requirements
Module: safe_lock_ctrl

---
 rtl/safe_lock_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_safe_lock_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/safe_lock_ctrl.sv
// ---------------------------------------------------------------------------
// safe_lock_ctrl -- keypad-driven electronic safe lock controller.
//
// Collects four BCD digits from a keypad, compares them against a stored
// password and either opens the lock or counts a failure. After MAX_TRIES
// consecutive failures the lock enters a timed ALARM state in which every
// key is ignored. While open, the user may store a new password or relock.
//
// Ports:
//   clk        in   1   single clock, everything on its rising edge
//   rst        in   1   synchronous active-high reset
//   key_valid  in   1   key_code is valid this cycle
//   key_code   in   4   0-9 digit, A enter, B clear, C change pw, D lock
//   unlocked   out  1   high only while in OPEN
//   alarm      out  1   high only while in ALARM
//   entry_cnt  out  3   digits held in the entry buffer (0..4)
//   disp       out  16  entry buffer, first digit in [15:12], empty = 4'hF
//   fail_cnt   out  2   consecutive failed checks
//   state      out  3   LOCKED=0, CHECK=1, OPEN=2, SET_NEW=3, ALARM=4
// ---------------------------------------------------------------------------
module safe_lock_ctrl #(
    parameter logic [15:0] DEFAULT_PW   = 16'h1234,
    parameter logic [1:0]  MAX_TRIES    = 2'd3,
    parameter logic [15:0] ALARM_CYCLES = 16'd1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        unlocked,
    output logic        alarm,
    output logic [2:0]  entry_cnt,
    output logic [15:0] disp,
    output logic [1:0]  fail_cnt,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_LOCKED  = 3'd0,
        S_CHECK   = 3'd1,
        S_OPEN    = 3'd2,
        S_SET_NEW = 3'd3,
        S_ALARM   = 3'd4
    } state_t;

    localparam logic [15:0] BUF_EMPTY = 16'hFFFF;
    localparam logic [3:0]  K_ENTER   = 4'hA;
    localparam logic [3:0]  K_CLEAR   = 4'hB;
    localparam logic [3:0]  K_CHANGE  = 4'hC;
    localparam logic [3:0]  K_LOCK    = 4'hD;

    state_t      state_q, state_d;
    logic [15:0] buf_q, buf_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  fail_q, fail_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] pw_q, pw_d;
    logic        unlocked_q, alarm_q;

    logic        is_digit_s;
    logic        buf_full_s;
    logic [1:0]  fail_inc_s;

    // Place digit d at entry position idx (position 0 is the leftmost nibble).
    function automatic logic [15:0] put_digit(input logic [15:0] b,
                                              input logic [1:0]  idx,
                                              input logic [3:0]  d);
        logic [15:0] r;
        r = b;
        case (idx)
            2'd0:    r[15:12] = d;
            2'd1:    r[11:8]  = d;
            2'd2:    r[7:4]   = d;
            2'd3:    r[3:0]   = d;
            default: r        = b;
        endcase
        return r;
    endfunction

    assign is_digit_s = key_valid && (key_code <= 4'd9);
    assign buf_full_s = (cnt_q == 3'd4);
    assign fail_inc_s = fail_q + 2'd1;

    // Next-state and datapath update for the lock FSM.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        timer_d = timer_q;
        pw_d    = pw_q;

        case (state_q)
            S_LOCKED, S_SET_NEW: begin
                if (is_digit_s && !buf_full_s) begin
                    buf_d = put_digit(buf_q, cnt_q[1:0], key_code);
                    cnt_d = cnt_q + 3'd1;
                end else if (key_valid && key_code == K_CLEAR) begin
                    buf_d = BUF_EMPTY;
                    cnt_d = 3'd0;
                end else if (key_valid && key_code == K_ENTER && buf_full_s) begin
                    if (state_q == S_LOCKED) begin
                        state_d = S_CHECK;
                    end else begin
                        // Commit the new password and return to OPEN.
                        pw_d    = buf_q;
                        buf_d   = BUF_EMPTY;
                        cnt_d   = 3'd0;
                        state_d = S_OPEN;
                    end
                end else if (key_valid && key_code == K_LOCK && state_q == S_SET_NEW) begin
                    buf_d   = BUF_EMPTY;
                    cnt_d   = 3'd0;
                    state_d = S_LOCKED;
                end else begin
                    state_d = state_q;
                end
            end
            S_CHECK: begin
                // Single-cycle compare; keys arriving now are dropped.
                buf_d = BUF_EMPTY;
                cnt_d = 3'd0;
                if (buf_q == pw_q) begin
                    fail_d  = 2'd0;
                    state_d = S_OPEN;
                end else begin
                    fail_d = fail_inc_s;
                    if (fail_inc_s == MAX_TRIES) begin
                        timer_d = ALARM_CYCLES - 16'd1;
                        state_d = S_ALARM;
                    end else begin
                        state_d = S_LOCKED;
                    end
                end
            end
            S_OPEN: begin
                if (key_valid && key_code == K_LOCK) begin
                    state_d = S_LOCKED;
                end else if (key_valid && key_code == K_CHANGE) begin
                    buf_d   = BUF_EMPTY;
                    cnt_d   = 3'd0;
                    state_d = S_SET_NEW;
                end else begin
                    state_d = state_q;
                end
            end
            S_ALARM: begin
                // Timer counts ALARM_CYCLES-1 down to 0, then one more cycle.
                if (timer_q == 16'd0) begin
                    fail_d  = 2'd0;
                    state_d = S_LOCKED;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: begin
                buf_d   = BUF_EMPTY;
                cnt_d   = 3'd0;
                timer_d = 16'd0;
                state_d = S_LOCKED;
            end
        endcase
    end

    // State, datapath and registered output flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_LOCKED;
            buf_q      <= BUF_EMPTY;
            cnt_q      <= 3'd0;
            fail_q     <= 2'd0;
            timer_q    <= 16'd0;
            pw_q       <= DEFAULT_PW;
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            fail_q     <= fail_d;
            timer_q    <= timer_d;
            pw_q       <= pw_d;
            unlocked_q <= (state_d == S_OPEN);
            alarm_q    <= (state_d == S_ALARM);
        end
    end

    assign unlocked  = unlocked_q;
    assign alarm     = alarm_q;
    assign entry_cnt = cnt_q;
    assign disp      = buf_q;
    assign fail_cnt  = fail_q;
    assign state     = state_q;

endmodule

// File: tb/tb_safe_lock_ctrl.sv
// ---------------------------------------------------------------------------
// tb_safe_lock_ctrl -- directed self-checking bench for safe_lock_ctrl.
// Keys are driven at the falling edge and held for one cycle; outputs are
// sampled at the falling edge after the rising edge that consumed them.
// ---------------------------------------------------------------------------
module tb_safe_lock_ctrl;

    localparam logic [15:0] ALARM_N = 16'd12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        unlocked, alarm;
    logic [2:0]  entry_cnt;
    logic [15:0] disp;
    logic [1:0]  fail_cnt;
    logic [2:0]  state;

    int n_tests = 0;
    int n_fail  = 0;
    int n_alarm;

    safe_lock_ctrl #(
        .DEFAULT_PW  (16'h1234),
        .MAX_TRIES   (2'd3),
        .ALARM_CYCLES(ALARM_N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_valid(key_valid),
        .key_code (key_code),
        .unlocked (unlocked),
        .alarm    (alarm),
        .entry_cnt(entry_cnt),
        .disp     (disp),
        .fail_cnt (fail_cnt),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic press4(input logic [15:0] d);
        press(d[15:12]);
        press(d[11:8]);
        press(d[7:4]);
        press(d[3:0]);
    endtask

    // One reset edge, optionally with a key presented at the same time.
    task automatic pulse_reset(input logic with_key);
        @(negedge clk);
        rst       = 1'b1;
        key_valid = with_key;
        key_code  = 4'h5;
        @(negedge clk);
        rst       = 1'b0;
        key_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_state"},    32'(state),     32'd0);
        check_eq({tag, "_unlocked"}, 32'(unlocked),  32'd0);
        check_eq({tag, "_alarm"},    32'(alarm),     32'd0);
        check_eq({tag, "_entry"},    32'(entry_cnt), 32'd0);
        check_eq({tag, "_disp"},     32'(disp),      32'hFFFF);
        check_eq({tag, "_fail"},     32'(fail_cnt),  32'd0);
    endtask

    // Enter a code, press A and verify the result two cycles after A.
    task automatic try_code(input string tag, input logic [15:0] code,
                            input logic [2:0] exp_state, input logic [1:0] exp_fail);
        press4(code);
        press(4'hA);
        check_eq({tag, "_check"}, 32'(state), 32'd1);
        @(negedge clk);
        check_eq({tag, "_state"}, 32'(state), 32'(exp_state));
        check_eq({tag, "_fail"},  32'(fail_cnt), 32'(exp_fail));
        check_eq({tag, "_disp"},  32'(disp), 32'hFFFF);
    endtask

    initial begin
        // Reset
        pulse_reset(1'b0);
        check_reset_vals("rst");

        // Correct password opens with two-cycle latency
        press(4'h1);
        check_eq("d1_cnt", 32'(entry_cnt), 32'd1);
        check_eq("d1_disp", 32'(disp), 32'h1FFF);
        press(4'h2);
        check_eq("d2_disp", 32'(disp), 32'h12FF);
        press(4'h3);
        check_eq("d3_cnt", 32'(entry_cnt), 32'd3);
        press(4'h4);
        check_eq("d4_cnt", 32'(entry_cnt), 32'd4);
        check_eq("d4_disp", 32'(disp), 32'h1234);
        press(4'hA);
        check_eq("chk_state", 32'(state), 32'd1);
        check_eq("chk_unl", 32'(unlocked), 32'd0);
        @(negedge clk);
        check_eq("open_unl", 32'(unlocked), 32'd1);
        check_eq("open_state", 32'(state), 32'd2);
        check_eq("open_fail", 32'(fail_cnt), 32'd0);
        check_eq("open_disp", 32'(disp), 32'hFFFF);
        press(4'hD);
        check_eq("relock", 32'(state), 32'd0);
        check_eq("relock_unl", 32'(unlocked), 32'd0);

        // A with short entry ignored, E ignored
        press(4'h1);
        press(4'h2);
        press(4'hA);
        check_eq("shortA_state", 32'(state), 32'd0);
        check_eq("shortA_cnt", 32'(entry_cnt), 32'd2);
        press(4'hE);
        check_eq("E_cnt", 32'(entry_cnt), 32'd2);
        check_eq("E_disp", 32'(disp), 32'h12FF);
        press(4'hB);
        check_eq("B_disp", 32'(disp), 32'hFFFF);
        check_eq("B_cnt", 32'(entry_cnt), 32'd0);

        // Three failures lead to ALARM
        try_code("f1", 16'h1235, 3'd0, 2'd1);
        try_code("f2", 16'h1235, 3'd0, 2'd2);
        press4(16'h1235);
        press(4'hA);
        check_eq("f3_check", 32'(state), 32'd1);
        check_eq("f3_noalarm", 32'(alarm), 32'd0);
        @(negedge clk);
        check_eq("f3_alarm", 32'(alarm), 32'd1);
        check_eq("f3_state", 32'(state), 32'd4);
        // Count alarm cycles while hammering keys that must be ignored
        n_alarm   = 1;
        key_valid = 1'b1;
        key_code  = 4'h1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!alarm) break;
            n_alarm++;
            key_code = (key_code == 4'h1) ? 4'hA : 4'h1;
        end
        key_valid = 1'b0;
        check_eq("alarm_len", 32'(n_alarm), 32'(ALARM_N));
        check_eq("alarm_exit_state", 32'(state), 32'd0);
        check_eq("alarm_exit_fail", 32'(fail_cnt), 32'd0);
        check_eq("alarm_keys_ign", 32'(entry_cnt), 32'd0);

        // Clear mid-entry, fifth digit ignored, then mismatch
        press(4'h1);
        press(4'h2);
        press(4'hB);
        press4(16'h7730);
        press(4'h9);
        check_eq("fifth_disp", 32'(disp), 32'h7730);
        check_eq("fifth_cnt", 32'(entry_cnt), 32'd4);
        press(4'hA);
        @(negedge clk);
        check_eq("7730_fail", 32'(fail_cnt), 32'd1);
        check_eq("7730_state", 32'(state), 32'd0);

        // Change password to 9876
        try_code("o1", 16'h1234, 3'd2, 2'd0);
        press(4'hC);
        check_eq("setnew_state", 32'(state), 32'd3);
        check_eq("setnew_unl", 32'(unlocked), 32'd0);
        press(4'h5);
        press(4'hA);
        check_eq("setnew_shortA", 32'(state), 32'd3);
        press(4'hB);
        press4(16'h9876);
        press(4'hA);
        check_eq("setnew_commit", 32'(state), 32'd2);
        check_eq("setnew_commit_unl", 32'(unlocked), 32'd1);
        press(4'hD);
        try_code("oldpw", 16'h1234, 3'd0, 2'd1);
        try_code("newpw", 16'h9876, 3'd2, 2'd0);
        check_eq("newpw_unl", 32'(unlocked), 32'd1);

        // SET_NEW then D keeps password; reset in SET_NEW restores default
        press(4'hC);
        press4(16'h1111);
        press(4'hD);
        check_eq("setnew_D_state", 32'(state), 32'd0);
        check_eq("setnew_D_disp", 32'(disp), 32'hFFFF);
        try_code("keep", 16'h9876, 3'd2, 2'd0);
        press(4'hC);
        press(4'h4);
        pulse_reset(1'b1);
        check_reset_vals("rst_setnew");
        try_code("default_back", 16'h1234, 3'd2, 2'd0);
        press(4'hD);

        // Reset during ALARM, with a key presented on the reset edge
        try_code("g1", 16'h0000, 3'd0, 2'd1);
        try_code("g2", 16'h0000, 3'd0, 2'd2);
        try_code("g3", 16'h0000, 3'd4, 2'd3);
        repeat (3) @(negedge clk);
        check_eq("g_alarm_hold", 32'(alarm), 32'd1);
        pulse_reset(1'b1);
        check_reset_vals("rst_alarm");
        try_code("after_alarm_rst", 16'h1234, 3'd2, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_tests);
        $fatal(1, "timeout");
    end

endmodule
